tri_ingress_fifo: RTL and testbench

//  Receiving end of the triangle-input interface (tri_R10S/color_R10U/validTri_R10H/halt_RnnnnL).

---
 rtl/rast_pkg.sv | 20 ++
 rtl/tri_ingress_fifo_if.sv | 27 ++
 rtl/tri_ingress_fifo.sv | 88 ++++++++
 tb/tb_tri_ingress_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rast_pkg.sv
// Shared rasterizer types: triangle geometry/colour payload and FIFO defaults.
package rast_pkg;

  localparam int unsigned SIGFIG                 = 24;
  localparam int unsigned VERTS                  = 3;
  localparam int unsigned AXIS                   = 3;
  localparam int unsigned COLORS                 = 3;
  localparam int unsigned TRI_FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned TRI_COUNT_W            = 32;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_vert_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                 tri_color_t;
  typedef logic [TRI_COUNT_W-1:0]                        tri_count_t;

  typedef struct packed {
    tri_vert_t  v;
    tri_color_t c;
  } tri_pkt_t;

endpackage

// File: rtl/tri_ingress_fifo_if.sv
// Triangle ingress bus: upstream offer/halt pair plus the bbox-facing re-presented stream.
interface tri_ingress_fifo_if;
  import rast_pkg::*;

  tri_vert_t  tri_R10S;
  tri_color_t color_R10U;
  logic       validTri_R10H;
  logic       halt_RnnnnL;
  tri_vert_t  triOut_R10S;
  tri_color_t colorOut_R10U;
  logic       validTriOut_R10H;
  logic       haltOut_RnnnnL;
  tri_count_t triCount_RnnnnU;

  // Environment side: drives upstream triangles and the bbox halt.
  modport master (
    output tri_R10S, color_R10U, validTri_R10H, haltOut_RnnnnL,
    input  halt_RnnnnL, triOut_R10S, colorOut_R10U, validTriOut_R10H, triCount_RnnnnU
  );

  // FIFO side.
  modport slave (
    input  tri_R10S, color_R10U, validTri_R10H, haltOut_RnnnnL,
    output halt_RnnnnL, triOut_R10S, colorOut_R10U, validTriOut_R10H, triCount_RnnnnU
  );

endinterface

// File: rtl/tri_ingress_fifo.sv
// Head-of-rast triangle FIFO: absorbs upstream stalls and re-presents triangles in order to bbox.
module tri_ingress_fifo
  import rast_pkg::*;
#(
  parameter int unsigned DEPTH = TRI_FIFO_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  tri_ingress_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  tri_pkt_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  tri_count_t         tri_count;

  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               pop_c;
  tri_pkt_t           wr_pkt_c;
  tri_pkt_t           head_pkt_c;

  // Flags come only from the registered count, so halt has no path from any input.
  assign full_c  = (count == FULL_CNT);
  assign empty_c = (count == '0);
  assign push_c  = bus.validTri_R10H & ~full_c & ~rst;
  assign pop_c   = ~empty_c & bus.haltOut_RnnnnL & ~rst;

  assign wr_pkt_c   = '{v: bus.tri_R10S, c: bus.color_R10U};
  assign head_pkt_c = mem[rd_ptr];

  // Storage has no reset; entries beyond the live window are never observed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_pkt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tri_count <= '0;
    end else begin
      if (push_c) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        tri_count <= tri_count + TRI_COUNT_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.halt_RnnnnL      = ~full_c;
  assign bus.validTriOut_R10H = ~empty_c;
  assign bus.triOut_R10S      = head_pkt_c.v;
  assign bus.colorOut_R10U    = head_pkt_c.c;
  assign bus.triCount_RnnnnU  = tri_count;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT)
    else $error("tri_ingress_fifo: count %0d exceeds depth", count);

  a_no_push_when_halted: assert property (@(posedge clk) disable iff (rst)
    !(push_c && !bus.halt_RnnnnL))
    else $error("tri_ingress_fifo: push while halt_RnnnnL low");

  // A stalled head must stay put until bbox takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.validTriOut_R10H && !bus.haltOut_RnnnnL) |=>
      (bus.validTriOut_R10H && $stable(bus.triOut_R10S) && $stable(bus.colorOut_R10U)))
    else $error("tri_ingress_fifo: head changed while stalled");
`endif

endmodule

// File: tb/tb_tri_ingress_fifo.sv
// Directed-vector and random scoreboard bench for tri_ingress_fifo.
module tb_tri_ingress_fifo;
  import rast_pkg::*;

  typedef struct {
    logic        rst;
    logic        vin;
    logic        hout;
    int unsigned id;
    logic        exp_valid;
    logic        exp_halt;
    int unsigned exp_id;
    int unsigned exp_tc;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  tri_ingress_fifo_if bus();

  tri_ingress_fifo #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tri_pkt_t mk_pkt(input int unsigned id);
    tri_pkt_t p;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p.v[2'(i)][2'(j)] = SIGFIG'(id * 32'd131 + 32'(i) * 32'd17 + 32'(j)) ^ 24'h800001;
      end
      p.c[2'(i)] = SIGFIG'(id * 32'd7 + 32'(i) + 32'd1);
    end
    return p;
  endfunction

  function automatic tri_pkt_t got_pkt();
    tri_pkt_t p;
    p.v = bus.triOut_R10S;
    p.c = bus.colorOut_R10U;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_pkt(input string name, input tri_pkt_t got, input tri_pkt_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic vin, input logic hout, input int unsigned id,
                     input logic ev, input logic eh, input int unsigned eid, input int unsigned etc);
    vec_t v;
    v = '{rst: r, vin: vin, hout: hout, id: id,
          exp_valid: ev, exp_halt: eh, exp_id: eid, exp_tc: etc};
    vecs.push_back(v);
  endtask

  // Drive each row on the falling edge, check the post-edge state 1 time unit after the rising edge.
  task automatic run_vecs(input string tag);
    tri_pkt_t p;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst               = vecs[i].rst;
      p                 = mk_pkt(vecs[i].id);
      bus.validTri_R10H = vecs[i].vin;
      bus.tri_R10S      = p.v;
      bus.color_R10U    = p.c;
      bus.haltOut_RnnnnL = vecs[i].hout;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].valid", tag, i), 32'(bus.validTriOut_R10H), 32'(vecs[i].exp_valid));
      chk($sformatf("%s[%0d].halt", tag, i), 32'(bus.halt_RnnnnL), 32'(vecs[i].exp_halt));
      chk($sformatf("%s[%0d].tricount", tag, i), bus.triCount_RnnnnU, vecs[i].exp_tc);
      if (vecs[i].exp_valid) begin
        chk_pkt($sformatf("%s[%0d].head", tag, i), got_pkt(), mk_pkt(vecs[i].exp_id));
      end
    end
    vecs.delete();
  endtask

  initial begin
    tri_pkt_t    q10;
    tri_pkt_t    model_q[$];
    tri_pkt_t    np;
    int unsigned next_id;
    logic [31:0] model_tc;
    logic        vin;
    logic        hout;
    logic        exp_halt;
    logic        exp_valid;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.validTri_R10H  = 1'b0;
    bus.haltOut_RnnnnL = 1'b0;
    bus.tri_R10S       = '0;
    bus.color_R10U     = '0;

    // Reset held while upstream is offering.
    for (int k = 0; k < 5; k++) add(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 0, 0);
    run_vecs("reset_hold");

    // Pass-through of a Q.10 triangle.
    q10 = '0;
    q10.v[0][0] = 24'sd1024;
    q10.v[0][1] = 24'sd2048;
    q10.v[0][2] = 24'sd512;
    q10.c[0]    = 24'h3FF;
    @(negedge clk);
    rst = 1'b0;
    bus.validTri_R10H  = 1'b1;
    bus.tri_R10S       = q10.v;
    bus.color_R10U     = q10.c;
    bus.haltOut_RnnnnL = 1'b1;
    @(posedge clk);
    #1;
    chk("pass.valid_n1", 32'(bus.validTriOut_R10H), 32'd1);
    chk("pass.halt_n1", 32'(bus.halt_RnnnnL), 32'd1);
    chk("pass.tricount_n1", bus.triCount_RnnnnU, 32'd1);
    chk_pkt("pass.data_n1", got_pkt(), q10);
    @(negedge clk);
    bus.validTri_R10H = 1'b0;
    @(posedge clk);
    #1;
    chk("pass.valid_n2", 32'(bus.validTriOut_R10H), 32'd0);
    chk("pass.tricount_n2", bus.triCount_RnnnnU, 32'd1);

    // Fill to full under bbox halt, 5th offer held, then drain in order.
    add(1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1, 10, 2);
    add(1'b0, 1'b1, 1'b0, 11, 1'b1, 1'b1, 10, 3);
    add(1'b0, 1'b1, 1'b0, 12, 1'b1, 1'b1, 10, 4);
    add(1'b0, 1'b1, 1'b0, 13, 1'b1, 1'b0, 10, 5);
    add(1'b0, 1'b1, 1'b0, 14, 1'b1, 1'b0, 10, 5);
    add(1'b0, 1'b1, 1'b1, 14, 1'b1, 1'b1, 11, 5);
    add(1'b0, 1'b1, 1'b1, 14, 1'b1, 1'b1, 12, 6);
    add(1'b0, 1'b0, 1'b1, 0,  1'b1, 1'b1, 13, 6);
    add(1'b0, 1'b0, 1'b1, 0,  1'b1, 1'b1, 14, 6);
    add(1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b1, 0,  6);
    run_vecs("fill");

    // Concurrent push/pop at occupancy 2; pointers wrap several times.
    add(1'b0, 1'b1, 1'b0, 20, 1'b1, 1'b1, 20, 7);
    add(1'b0, 1'b1, 1'b0, 21, 1'b1, 1'b1, 20, 8);
    for (int k = 0; k < 20; k++) begin
      add(1'b0, 1'b1, 1'b1, 22 + k, 1'b1, 1'b1, 21 + k, 9 + k);
    end
    run_vecs("concurrent");

    // Mid-stream reset at occupancy 3, then a fresh push.
    add(1'b0, 1'b1, 1'b0, 50, 1'b1, 1'b1, 40, 29);
    add(1'b1, 1'b1, 1'b1, 51, 1'b0, 1'b1, 0,  0);
    add(1'b0, 1'b1, 1'b0, 60, 1'b1, 1'b1, 60, 1);
    add(1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b1, 0,  1);
    run_vecs("midreset");

    // Random traffic against a queue model.
    @(negedge clk);
    rst = 1'b1;
    bus.validTri_R10H = 1'b0;
    @(posedge clk);
    next_id  = 1000;
    model_tc = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst  = 1'b0;
      vin  = (($urandom % 4) != 0);
      hout = (($urandom % 2) != 0);
      np   = mk_pkt(next_id);
      bus.validTri_R10H  = vin;
      bus.tri_R10S       = np.v;
      bus.color_R10U     = np.c;
      bus.haltOut_RnnnnL = hout;
      #1;
      exp_halt  = (model_q.size() != 4);
      exp_valid = (model_q.size() != 0);
      chk("rand.halt", 32'(bus.halt_RnnnnL), 32'(exp_halt));
      chk("rand.valid", 32'(bus.validTriOut_R10H), 32'(exp_valid));
      chk("rand.tricount", bus.triCount_RnnnnU, model_tc);
      if (exp_valid) chk_pkt("rand.head", got_pkt(), model_q[0]);
      @(posedge clk);
      if (hout && exp_valid) void'(model_q.pop_front());
      if (vin && exp_halt) begin
        model_q.push_back(np);
        next_id++;
        model_tc++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
